// File: rtl/matrix_pkg.sv
// Shared constants, opcode encoding and sequencer state encoding for the packed 5x5 matrix engines.
// Element k of a packed matrix lives at bits [k*ELEM_W +: ELEM_W], k = row*DIM + col.
package matrix_pkg;

  localparam int DIM       = 5;
  localparam int ELEM_W    = 8;
  localparam int MAT_W     = DIM * DIM * ELEM_W;
  localparam int ROW_W     = DIM * ELEM_W;
  localparam int ROW_IDX_W = $clog2(DIM);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/matrix_row_alu.sv
// Row-wide signed add/subtract over DIM elements, wrapping to ELEM_W bits, with OR-reduced overflow.
// Purely combinational: zero latency, no flow control.
module matrix_row_alu
  import matrix_pkg::*;
(
  input  logic [ROW_W-1:0] row_a,
  input  logic [ROW_W-1:0] row_b,
  input  logic             sub,
  output logic [ROW_W-1:0] row_r,
  output logic             row_ovf
);

  logic [ELEM_W-1:0] elem_r [DIM];
  logic [DIM-1:0]    elem_ovf;

  for (genvar e = 0; e < DIM; e++) begin : g_elem
    logic [ELEM_W-1:0] ea;
    logic [ELEM_W-1:0] eb;
    logic [ELEM_W-1:0] er;

    // Subtract as A + ~B + 1; the inverted operand's sign makes one overflow rule cover both ops.
    assign ea          = row_a[e*ELEM_W +: ELEM_W];
    assign eb          = sub ? ~row_b[e*ELEM_W +: ELEM_W] : row_b[e*ELEM_W +: ELEM_W];
    assign er          = ea + eb + ELEM_W'(sub);
    assign elem_r[e]   = er;
    assign elem_ovf[e] = (ea[ELEM_W-1] == eb[ELEM_W-1]) && (er[ELEM_W-1] != ea[ELEM_W-1]);
  end

  always_comb begin
    row_r = '0;
    for (int e = 0; e < DIM; e++) begin
      row_r[e*ELEM_W +: ELEM_W] = elem_r[e];
    end
  end

  assign row_ovf = |elem_ovf;

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequenced 5x5 element-wise add/subtract: latches operands on start, runs one row per cycle through a shared row ALU.
// Latency: done pulses DIM+1 cycles after accept (1 for a reserved opcode); start is ignored unless ready.
module matrix_op_sequencer
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [MAT_W-1:0] matrix_A,
  input  logic [MAT_W-1:0] matrix_B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [MAT_W-1:0] result_out,
  output logic             overflow,
  output logic             error
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(DIM - 1);

  state_t               state_q;
  logic [ROW_IDX_W-1:0] row_q;
  logic [MAT_W-1:0]     a_q;
  logic [MAT_W-1:0]     b_q;
  logic [MAT_W-1:0]     result_q;
  logic                 sub_q;
  logic                 ovf_q;
  logic                 err_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 ready_q;

  logic [ROW_W-1:0]     row_a;
  logic [ROW_W-1:0]     row_b;
  logic [ROW_W-1:0]     row_r;
  logic                 row_ovf;
  logic [MAT_W-1:0]     result_d;

  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int r = 0; r < DIM; r++) begin
      if (row_q == ROW_IDX_W'(r)) begin
        row_a = a_q[r*ROW_W +: ROW_W];
        row_b = b_q[r*ROW_W +: ROW_W];
      end
    end
  end

  matrix_row_alu u_row_alu (
    .row_a   (row_a),
    .row_b   (row_b),
    .sub     (sub_q),
    .row_r   (row_r),
    .row_ovf (row_ovf)
  );

  // Only the active row is replaced; earlier rows keep their freshly written results.
  always_comb begin
    result_d = result_q;
    for (int r = 0; r < DIM; r++) begin
      if (row_q == ROW_IDX_W'(r)) begin
        result_d[r*ROW_W +: ROW_W] = row_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= matrix_A;
            b_q     <= matrix_B;
            sub_q   <= (opcode == OP_SUB);
            ovf_q   <= 1'b0;
            row_q   <= '0;
            ready_q <= 1'b0;
            if (op_is_valid(opcode)) begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= EXEC;
            end else begin
              // Reserved opcode: report immediately and leave the previous result in place.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        EXEC: begin
          result_q <= result_d;
          ovf_q    <= ovf_q | row_ovf;
          if (row_q == LAST_ROW) begin
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            row_q <= row_q + ROW_IDX_W'(1);
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result_out = result_q;
  assign overflow   = ovf_q;
  assign error      = err_q;

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Sequenced element-wise add/subtract engine for 5x5 signed 8-bit matrices, using the same packed 200-bit matrix format as the subtractor datapath. It accepts an operation through a start/ready handshake and latches both operands. It processes one row per clock through a shared row-wide ALU and reports the result, a sticky signed-overflow flag and a one-cycle done pulse. It sits between the control FSM and the matrix arithmetic units so that a single row ALU serves both add and subtract.

Parameters:
DIM, 5, matrix rows/columns
ELEM_W, 8, signed element width in bits
MAT_W, DIM*DIM*ELEM_W (200), packed matrix width, derived, not overridable

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  operation request, sampled only while ready=1
opcode  in  2  2'b00 ADD (A+B), 2'b01 SUB (A-B), 2'b1x reserved
matrix_A  in  MAT_W  operand A, element k at bits [k*ELEM_W +: ELEM_W], k=i*DIM+j
matrix_B  in  MAT_W  operand B, same packing
ready  out  1  idle, able to accept start
busy  out  1  operation in progress
done  out  1  one-cycle pulse; result_out/overflow/error valid
result_out  out  MAT_W  result matrix, same packing
overflow  out  1  any element overflowed in the last operation
error  out  1  last operation had a reserved opcode

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, row=0, operand registers=0, result_out=0, overflow=0, error=0, done=0, busy=0, ready=1. Reset mid-operation aborts with no done pulse.
- States: IDLE, EXEC, DONE.
- IDLE: ready=1. On start=1 (accept cycle T), latch A, B and opcode, clear overflow and error, row=0.
  - Valid opcode: go to EXEC.
  - Reserved opcode: set error=1 and go to DONE. result_out is unchanged.
- EXEC: busy=1, ready=0. Each cycle, row r of the latched operands (elements r*DIM..r*DIM+DIM-1) passes through the row ALU.
  - The row result is written into result_out row r.
  - overflow |= row overflow.
  - row increments; after row DIM-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE. For a valid op, done is asserted at T+DIM+1 (T+6); for a reserved opcode, at T+1. ready reasserts at T+DIM+2.
- Arithmetic: two's complement, result truncated to ELEM_W bits (wraps).
  - ADD overflow: sign(A)==sign(B) and sign(R)!=sign(A).
  - SUB overflow: sign(A)!=sign(B) and sign(R)!=sign(A).
- start, opcode and operand changes while busy or in DONE are ignored. Operands are used only from the latched copy.
- result_out rows update in place during EXEC. Consumers sample result_out only on done or while ready=1.
- overflow and error hold their values until the next accept.

Decomposition:
- Shared package matrix_pkg holds:
  - DIM, ELEM_W, MAT_W
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01
  - state encoding IDLE/EXEC/DONE
- One sub-module, matrix_row_alu: combinational, DIM elements wide.
  - Inputs: row_a, row_b, sub.
  - Outputs: row_r, row_ovf (OR of element overflows).
- Row select/insert muxes and the FSM stay in matrix_op_sequencer.

Test Plan:
1. Reset: hold rst_n=0 with start=1 -> ready=1, busy=0, done=0, overflow=0, error=0, result_out=0. After release, no operation starts until start is sampled high in IDLE.
2. SUB, A[k]=10*(k+1), B[k]=k+1 (byte values) -> R[k]=9*(k+1) mod 256. overflow=1 (k=12: -126-13). done exactly 6 cycles after accept; ready=1 the cycle after done.
3. SUB, A[k]=-5*(k+1), B[k]=-(k+1) -> R[k]=-4*(k+1) (k=24: -100). overflow=0.
4. All A=127, B=-128:
   - SUB -> every R=-1 (8'hFF), overflow=1.
   - Back-to-back ADD with the same operands -> every R=-1, overflow=0 (cleared on accept).
5. Hold start=1 and change opcode/operands during EXEC -> the in-flight result is unaffected and only one done pulse occurs. The next accept happens only on a cycle with ready=1.
6. Reserved opcode:
   - opcode=2'b11 -> done at T+1, error=1, result_out unchanged.
   - Separately, drop rst_n during EXEC row 2 -> all outputs take reset values immediately and no done pulse occurs.
